// File: rtl/gd_pkg.sv
// Shared definitions for the N-dimensional gradient-descent controller:
// FSM encoding, exit causes and a generic signed saturation helper.
package gd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_REQ,
    S_WAIT,
    S_UPD,
    S_DONE
  } state_t;

  localparam logic [1:0] EXIT_MAXIT = 2'd0;
  localparam logic [1:0] EXIT_CONV  = 2'd1;
  localparam logic [1:0] EXIT_STEP  = 2'd2;

  // Clamp a sign-extended value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/gd_step_nd.sv
// Per-lane saturating step: res_i = sat(base_i - (g_i >>> sh)) in signed XW format.
module gd_step_nd
  import gd_pkg::*;
#(
  parameter int NUM_DIMS = 4,
  parameter int XW       = 16,
  parameter int SH_W     = 4
) (
  input  logic [NUM_DIMS*XW-1:0] base,
  input  logic [NUM_DIMS*XW-1:0] g,
  input  logic [SH_W-1:0]        sh,
  output logic [NUM_DIMS*XW-1:0] res
);

  generate
    for (genvar gi = 0; gi < NUM_DIMS; gi++) begin : g_lane
      logic signed [XW-1:0] b_l;
      logic signed [XW-1:0] g_l;
      logic signed [XW-1:0] d_l;
      logic signed [XW:0]   diff;
      logic [XW-1:0]        lane_res;

      // One guard bit is enough to hold any difference before clamping.
      always_comb begin
        b_l      = base[gi*XW +: XW];
        g_l      = g[gi*XW +: XW];
        d_l      = g_l >>> sh;
        diff     = {b_l[XW-1], b_l} - {d_l[XW-1], d_l};
        lane_res = XW'(sat_s({{(63 - XW){diff[XW]}}, diff}, XW));
      end

      assign res[gi*XW +: XW] = lane_res;
    end
  endgenerate

endmodule

// File: rtl/gd_ctrl_nd.sv
// Gradient-descent controller: drives an external evaluator, tracks the best point,
// backtracks with a halved step on non-improvement and reports why it stopped.
module gd_ctrl_nd
  import gd_pkg::*;
#(
  parameter int NUM_DIMS   = 4,
  parameter int INT_W      = 8,
  parameter int FRAC_W     = 8,
  parameter int Z_W        = 32,
  parameter int MAX_ITER   = 50,
  parameter int SHIFT_INIT = 2,
  parameter int SHIFT_MAX  = 10,
  parameter int CONV_TOL   = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [NUM_DIMS*INT_W-1:0]            x_init,
  output logic                                 eval_req,
  output logic [NUM_DIMS*(INT_W+FRAC_W)-1:0]   eval_x,
  input  logic                                 eval_done,
  input  logic [Z_W-1:0]                       eval_z,
  input  logic [NUM_DIMS*(INT_W+FRAC_W)-1:0]   eval_grad,
  output logic [Z_W-1:0]                       z_min,
  output logic [NUM_DIMS*INT_W-1:0]            x_min,
  output logic [$clog2(MAX_ITER+1)-1:0]        iter_used,
  output logic                                 done,
  output logic [1:0]                           exit_code
);

  localparam int XW   = INT_W + FRAC_W;
  localparam int IT_W = $clog2(MAX_ITER + 1);
  localparam int SH_W = $clog2(SHIFT_MAX + 3);

  localparam logic [Z_W-1:0]  Z_MAX    = {1'b0, {(Z_W - 1){1'b1}}};
  localparam logic [Z_W:0]    TOL      = (Z_W + 1)'(CONV_TOL);
  localparam logic [IT_W-1:0] IT_MAX   = IT_W'(MAX_ITER);
  localparam logic [SH_W-1:0] SH_START = SH_W'(SHIFT_INIT);
  localparam logic [SH_W-1:0] SH_LIM   = SH_W'(SHIFT_MAX);
  localparam logic [XW:0]     HALF     = (XW + 1)'(1) << (FRAC_W - 1);

  state_t                   state;
  logic [NUM_DIMS*XW-1:0]   x_best;
  logic [NUM_DIMS*XW-1:0]   g_best;
  logic [NUM_DIMS*XW-1:0]   grad_reg;
  logic [Z_W-1:0]           z_reg;
  logic [Z_W-1:0]           z_prev;
  logic [SH_W-1:0]          shift;
  logic                     first;

  logic                     improved;
  logic                     conv;
  logic                     exhaust;
  logic                     at_cap;
  logic [SH_W-1:0]          sh_inc;
  logic [SH_W-1:0]          step_sh;
  logic [NUM_DIMS*XW-1:0]   step_base;
  logic [NUM_DIMS*XW-1:0]   step_g;
  logic [NUM_DIMS*XW-1:0]   x_next;
  logic [NUM_DIMS*XW-1:0]   x_start;
  logic [NUM_DIMS*INT_W-1:0] x_min_next;
  logic signed [Z_W:0]      dz;
  logic [Z_W:0]             adz;

  // A non-improving step restarts from the best point with the next, smaller step.
  always_comb begin
    improved  = $signed(z_reg) < $signed(z_min);
    sh_inc    = shift + SH_W'(1);
    step_base = improved ? eval_x : x_best;
    step_g    = improved ? grad_reg : g_best;
    step_sh   = improved ? shift : sh_inc;
    dz        = $signed({z_reg[Z_W-1], z_reg}) - $signed({z_prev[Z_W-1], z_prev});
    adz       = dz[Z_W] ? -dz : dz;
    conv      = !first && (adz <= TOL);
    exhaust   = !improved && (sh_inc > SH_LIM);
    at_cap    = (iter_used == IT_MAX);
  end

  gd_step_nd #(
    .NUM_DIMS (NUM_DIMS),
    .XW       (XW),
    .SH_W     (SH_W)
  ) u_step (
    .base (step_base),
    .g    (step_g),
    .sh   (step_sh),
    .res  (x_next)
  );

  generate
    for (genvar gi = 0; gi < NUM_DIMS; gi++) begin : g_dim
      logic signed [XW:0] rnd;
      logic signed [XW:0] q;
      logic [INT_W-1:0]   xr_l;

      // Round half toward +inf, then clamp so 127.5 and above cannot wrap.
      always_comb begin
        rnd  = $signed({x_best[gi*XW+XW-1], x_best[gi*XW +: XW]}) + $signed(HALF);
        q    = rnd >>> FRAC_W;
        xr_l = INT_W'(sat_s({{(63 - XW){q[XW]}}, q}, INT_W));
      end

      assign x_min_next[gi*INT_W +: INT_W] = xr_l;
      assign x_start[gi*XW +: XW]          = {x_init[gi*INT_W +: INT_W], {FRAC_W{1'b0}}};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      eval_req  <= 1'b0;
      eval_x    <= '0;
      z_min     <= Z_MAX;
      x_min     <= '0;
      iter_used <= '0;
      done      <= 1'b0;
      exit_code <= EXIT_MAXIT;
      x_best    <= '0;
      g_best    <= '0;
      grad_reg  <= '0;
      z_reg     <= '0;
      z_prev    <= '0;
      shift     <= SH_START;
      first     <= 1'b1;
    end else begin
      eval_req <= 1'b0;
      x_min    <= x_min_next;
      case (state)
        S_IDLE: begin
          if (start) state <= S_INIT;
        end
        S_INIT: begin
          eval_x    <= x_start;
          x_best    <= x_start;
          z_min     <= Z_MAX;
          shift     <= SH_START;
          iter_used <= '0;
          first     <= 1'b1;
          done      <= 1'b0;
          eval_req  <= 1'b1;
          state     <= S_REQ;
        end
        S_REQ: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (eval_done) begin
            z_reg     <= eval_z;
            grad_reg  <= eval_grad;
            iter_used <= iter_used + IT_W'(1);
            state     <= S_UPD;
          end
        end
        S_UPD: begin
          if (improved) begin
            z_min  <= z_reg;
            x_best <= eval_x;
            g_best <= grad_reg;
          end else begin
            shift <= sh_inc;
          end
          eval_x <= x_next;
          z_prev <= z_reg;
          first  <= 1'b0;
          if (conv) begin
            exit_code <= EXIT_CONV;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (exhaust) begin
            exit_code <= EXIT_STEP;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (at_cap) begin
            exit_code <= EXIT_MAXIT;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            eval_req <= 1'b1;
            state    <= S_REQ;
          end
        end
        S_DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gd_ctrl_nd.sv
// Scoreboard bench for gd_ctrl_nd: a 2-cycle evaluator model answers requests,
// expected eval_x values and run results are queued and checked by a monitor.
module tb_gd_ctrl_nd;

  localparam int ND  = 4;
  localparam int IW  = 8;
  localparam int XW  = 16;
  localparam int ZW  = 32;
  localparam int ITW = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ND*IW-1:0]  x_init;
  logic              eval_req;
  logic [ND*XW-1:0]  eval_x;
  logic              eval_done;
  logic [ZW-1:0]     eval_z;
  logic [ND*XW-1:0]  eval_grad;
  logic [ZW-1:0]     z_min;
  logic [ND*IW-1:0]  x_min;
  logic [ITW-1:0]    iter_used;
  logic              done;
  logic [1:0]        exit_code;

  always #5 clk = ~clk;

  gd_ctrl_nd dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x_init    (x_init),
    .eval_req  (eval_req),
    .eval_x    (eval_x),
    .eval_done (eval_done),
    .eval_z    (eval_z),
    .eval_grad (eval_grad),
    .z_min     (z_min),
    .x_min     (x_min),
    .iter_used (iter_used),
    .done      (done),
    .exit_code (exit_code)
  );

  typedef struct {
    logic [1:0]       code;
    logic [ITW-1:0]   iters;
    logic [ZW-1:0]    zmin;
    logic [ND*IW-1:0] xmin;
  } result_t;

  result_t          res_q[$];
  logic [ND*XW-1:0] x_q[$];
  int               n_cmp = 0;
  int               n_bad = 0;
  int               mode = 0;
  int               eval_k = 0;
  bit               spurious = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input int v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  // Modes: 0 quadratic bowl at (3,-2,5,0); 1 f=x0^2 with steep grad 16*x0;
  // 2 ever-rising z; 3 ever-falling z with huge opposite-sign gradients.
  function automatic void model(input logic [63:0] xv, input int m, input int k,
                                output logic [31:0] z, output logic [63:0] g);
    int     e;
    longint acc;
    int     tgt[4];
    tgt = '{768, -512, 1280, 0};
    acc = 0;
    g = '0;
    z = '0;
    case (m)
      0: begin
        for (int i = 0; i < 4; i++) begin
          e = int'($signed(xv[i*16 +: 16])) - tgt[i];
          acc += longint'(e * e);
          g[i*16 +: 16] = sat16(2 * e);
        end
        z = 32'(acc >>> 8);
      end
      1: begin
        e = int'($signed(xv[15:0]));
        z = 32'((e * e) >>> 8);
        g[15:0] = sat16(16 * e);
      end
      2: z = 32'(1000 * k);
      default: begin
        z = 32'(-1000 * k);
        g = {16'h0000, 16'h0000, 16'h7FFF, 16'h8001};
      end
    endcase
  endfunction

  // Evaluator: sees a request at a falling edge, answers one cycle later.
  initial begin
    logic [63:0] xs;
    logic [31:0] zz;
    logic [63:0] gg;
    eval_done = 1'b0;
    eval_z    = '0;
    eval_grad = '0;
    forever begin
      @(negedge clk);
      eval_done = 1'b0;
      if (eval_req && rst_n) begin
        xs = eval_x;
        eval_k++;
        model(xs, mode, eval_k, zz, gg);
        if (spurious) begin
          spurious  = 1'b0;
          eval_done = 1'b1;
          eval_z    = 32'h8000_0000;
          eval_grad = '1;
        end
        @(negedge clk);
        eval_done = 1'b1;
        eval_z    = zz;
        eval_grad = gg;
      end
    end
  end

  // Monitor: checks eval_x on every request and the result one cycle after done rises.
  initial begin
    logic    done_d;
    bit      pend;
    result_t r;
    done_d = 1'b0;
    pend   = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        if (res_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got exit_code %0d, expected no completion", exit_code);
        end else begin
          r = res_q.pop_front();
          check("exit_code", 64'(exit_code), 64'(r.code));
          check("iter_used", 64'(iter_used), 64'(r.iters));
          check("z_min", 64'(z_min), 64'(r.zmin));
          check("x_min", 64'(x_min), 64'(r.xmin));
        end
      end
      if (eval_req) begin
        if (x_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_eval_req: got eval_x %h, expected no request", eval_x);
        end else begin
          check("eval_x", 64'(eval_x), 64'(x_q.pop_front()));
        end
      end
      if (done && !done_d) pend = 1'b1;
      done_d = done;
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_eval_req"}, 64'(eval_req), 64'd0);
    check({tag, "_eval_x"}, 64'(eval_x), 64'd0);
    check({tag, "_z_min"}, 64'(z_min), 64'h7FFF_FFFF);
    check({tag, "_x_min"}, 64'(x_min), 64'd0);
    check({tag, "_iter_used"}, 64'(iter_used), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_exit_code"}, 64'(exit_code), 64'd0);
  endtask

  task automatic run_case(input string name, input logic [31:0] xi, input int m, input int hold);
    int c;
    mode   = m;
    eval_k = 0;
    x_init = xi;
    @(negedge clk);
    start = 1'b1;
    c = 0;
    while (!done && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: done=0 after 3000 cycles, expected 1", name);
    end
    repeat (2 + hold) @(negedge clk);
    check({name, "_done_held"}, 64'(done), 64'd1);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check({name, "_done_clr"}, 64'(done), 64'd0);
  endtask

  // Errors halve each step: lanes 0..2 approach 768, -512, 1280 (Q8.8).
  task automatic push_quad();
    for (int k = 0; k < 6; k++) begin
      x_q.push_back({16'h0000, 16'(1280 - (1280 >> k)), 16'(-512 + (512 >> k)), 16'(768 - (768 >> k))});
    end
    res_q.push_back('{2'd1, 6'd6, 32'd9, 32'h0005_FE03});
  endtask

  initial begin
    int c;
    rst_n  = 1'b0;
    start  = 1'b0;
    x_init = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // A stray eval_done while idle must not count as an evaluation.
    @(negedge clk);
    #1 eval_done = 1'b1;
    eval_z = 32'd0;
    @(negedge clk);
    @(negedge clk);
    check("idle_done_iter", 64'(iter_used), 64'd0);
    check("idle_done_zmin", 64'(z_min), 64'h7FFF_FFFF);

    push_quad();
    run_case("quad", 32'h0, 0, 20);
    push_quad();
    run_case("quad_rerun", 32'h0, 0, 0);

    // Overshoot, two backtracks, then a zero-gradient stall ends in convergence.
    x_q.push_back(64'h0000_0000_0000_0400);
    x_q.push_back(64'h0000_0000_0000_F400);
    x_q.push_back(64'h0000_0000_0000_FC00);
    x_q.push_back(64'h0);
    x_q.push_back(64'h0);
    res_q.push_back('{2'd1, 6'd5, 32'd0, 32'h0});
    spurious = 1'b1;
    run_case("backtrack", 32'h0000_0004, 1, 0);

    for (int k = 0; k < 10; k++) x_q.push_back(64'hFC00_0300_0200_0100);
    res_q.push_back('{2'd2, 6'd10, 32'd1000, 32'hFC03_0201});
    run_case("exhaust", 32'hFC03_0201, 2, 0);

    x_q.push_back(64'h0000_0000_8000_7F00);
    for (int k = 1; k < 50; k++) x_q.push_back(64'h0000_0000_8000_7FFF);
    res_q.push_back('{2'd0, 6'd50, -32'sd50000, 32'h0000_807F});
    run_case("sat_cap", 32'h0000_807F, 3, 0);

    // Abort a run while the controller waits on the evaluator.
    mode   = 0;
    eval_k = 0;
    x_init = '0;
    x_q.push_back(64'h0);
    @(negedge clk);
    start = 1'b1;
    c = 0;
    while (!eval_req && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("abort_req_seen", 64'(eval_req), 64'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_values("abort");
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    push_quad();
    run_case("quad_after_abort", 32'h0, 0, 0);

    repeat (5) @(negedge clk);
    check("x_queue_left", 64'(x_q.size()), 64'd0);
    check("res_queue_left", 64'(res_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1ms, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
